// File: rtl/gerador_sequencia_pkg.sv
// gerador_sequencia_pkg
// Shared definitions for the sequence generator: FSM state codes, LFSR
// width/taps and the mapping from LFSR bits to a one-hot play.
package gerador_sequencia_pkg;

  localparam int LFSR_W = 16;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: the new MSB is the
  // XOR of bits 0, 2, 3 and 5 of the current value.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ZERA    = 3'd1,
    GERA    = 3'd2,
    ESCREVE = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // One-hot play selected by the two LSBs of the LFSR word.
  function automatic logic [3:0] one_hot(input logic [LFSR_W-1:0] v);
    one_hot = 4'b0001 << v[1:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16
// Free-running 16-bit Fibonacci LFSR, shifting on every rising clock edge.
// A zero seed would lock the register at zero, so it is replaced by 1.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high; loads the seed
//   q      out  current LFSR word
module lfsr16
  import gerador_sequencia_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] SEED_OK = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_q <= SEED_OK;
    else       r_q <= {w_fb, r_q[LFSR_W-1:1]};
  end

  assign q = r_q;

endmodule

// File: rtl/gerador_sequencia.sv
// gerador_sequencia
// Fills the game's sequence memory with DEPTH pseudo-random one-hot plays.
// While a fill runs the block owns the memory port; otherwise the game's read
// address passes straight through. iniciar is a level request sampled on the
// clock edge while idle (OCIOSO) or finishing (FIM); it is ignored while
// ocupado=1. pronto pulses for one cycle when the last entry has been written.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   iniciar             start request
//   endereco_jogo       game read address (passed through when idle)
//   mem_endereco        memory address
//   mem_dado            one-hot write data (data register, always visible)
//   mem_we              write enable, high only in ESCREVE
//   ocupado             fill in progress (ZERA..PROXIMO)
//   pronto              one-cycle completion pulse (FIM)
//   db_estado           current state code
module gerador_sequencia
  import gerador_sequencia_pkg::*;
#(
  parameter int                DEPTH         = 16,
  parameter int                ADDR_W        = 4,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter bit                SEM_REPETICAO = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] endereco_jogo,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [3:0]        mem_dado,
  output logic              mem_we,
  output logic              ocupado,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [ADDR_W-1:0] r_cont;
  logic [3:0]        r_dado;
  logic [LFSR_W-1:0] w_lfsr;
  logic [3:0]        w_cand;
  logic              w_rejeita;
  logic              w_ultimo;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (w_lfsr)
  );

  assign w_cand   = one_hot(w_lfsr);
  assign w_ultimo = (r_cont == ULTIMO);
  // r_dado still holds the previously written entry while in GERA, so a
  // repeat is detected against it. Entry 0 of a fill is always accepted.
  assign w_rejeita = SEM_REPETICAO && (r_cont != '0) && (w_cand == r_dado);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  if (iniciar) w_prox = ZERA;
      ZERA:    w_prox = GERA;
      GERA:    if (!w_rejeita) w_prox = ESCREVE;
      ESCREVE: w_prox = PROXIMO;
      PROXIMO: w_prox = w_ultimo ? FIM : GERA;
      FIM:     w_prox = iniciar ? ZERA : OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cont <= '0;
      r_dado <= 4'b0001;
    end else begin
      case (r_estado)
        ZERA:    r_cont <= '0;
        GERA:    if (!w_rejeita) r_dado <= w_cand;
        PROXIMO: if (!w_ultimo) r_cont <= r_cont + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    ocupado = 1'b0;
    pronto  = 1'b0;
    case (r_estado)
      ZERA, GERA, PROXIMO: ocupado = 1'b1;
      ESCREVE: begin
        ocupado = 1'b1;
        mem_we  = 1'b1;
      end
      FIM:     pronto = 1'b1;
      default: ;
    endcase
  end

  assign mem_endereco = ocupado ? r_cont : endereco_jogo;
  assign mem_dado     = r_dado;
  assign db_estado    = r_estado;

endmodule

// File: doc/gerador_sequencia.md
# gerador_sequencia

Controller that fills the game's sequence memory with pseudo-random one-hot plays before each round. It owns the memory's address/data/write-enable port. While filling, it drives the port itself. While idle, it passes the game datapath's read address straight through. A free-running LFSR supplies the entropy, and the player's timing of `iniciar` decides which part of the LFSR stream is used.

## Interface
- `DEPTH`, 16: number of memory entries written per fill.
- `ADDR_W`, 4: memory address width; DEPTH ≤ 2^ADDR_W.
- `SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `SEM_REPETICAO`, 1: when 1, two consecutive entries are never equal.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `iniciar`  in  1  start request, sampled on rising edge.
- `endereco_jogo`  in  ADDR_W  read address from the game datapath.
- `mem_endereco`  out  ADDR_W  address to the memory.
- `mem_dado`  out  4  one-hot write data to the memory.
- `mem_we`  out  1  memory write enable.
- `ocupado`  out  1  high while a fill is in progress.
- `pronto`  out  1  one-cycle pulse when a fill completes.
- `db_estado`  out  3  current state code, for debug.

## Operation
- States and codes:
  - OCIOSO=0: idle.
  - ZERA=1: address counter cleared to 0.
  - GERA=2: data register loaded.
  - ESCREVE=3: `mem_we`=1.
  - PROXIMO=4: advance or finish.
  - FIM=5: `pronto`=1.
- Transitions:
  - OCIOSO goes to ZERA when `iniciar`=1; otherwise stays in OCIOSO.
  - ZERA goes to GERA.
  - GERA goes to ESCREVE, except when a candidate is rejected; then it stays in GERA.
  - ESCREVE goes to PROXIMO.
  - PROXIMO goes to FIM if counter == DEPTH-1. Otherwise it increments the counter and goes to GERA.
  - FIM goes to ZERA if `iniciar`=1; otherwise it goes to OCIOSO.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shifts every clock in every state.
- Candidate in GERA comes from `lfsr[1:0]`:
  - 00 → 0001
  - 01 → 0010
  - 10 → 0100
  - 11 → 1000
- With `SEM_REPETICAO`=1, a candidate equal to the previously written entry is rejected and the FSM stays in GERA. The first entry of a fill is never rejected.
- Port arbitration:
  - When `ocupado`=1, `mem_endereco` = address counter.
  - Otherwise `mem_endereco` = `endereco_jogo`.
  - `mem_we`=1 only in ESCREVE.
  - `mem_dado` = data register in all states.
- `ocupado`=1 in ZERA, GERA, ESCREVE and PROXIMO.
- `iniciar` is ignored while `ocupado`=1.
- All outputs are Moore outputs, decoded from state and registers only.

## Timing
- Reset values (asserted asynchronously):
  - State OCIOSO, counter 0, data register 4'b0001, LFSR = SEED (or 1 if SEED is 0).
  - `mem_we`=0, `ocupado`=0, `pronto`=0, `db_estado`=0.
  - `mem_endereco` follows `endereco_jogo`.
- Latency for `iniciar` sampled at edge k, with no rejections:
  - ZERA in cycle k+1.
  - For entry i: GERA at k+2+3i, ESCREVE at k+3+3i, PROXIMO at k+4+3i.
  - FIM (`pronto`=1) at k+3·DEPTH+2, which is k+50 for DEPTH=16.
  - Each rejection adds exactly one cycle.
- Exactly DEPTH write cycles per fill, at addresses 0..DEPTH-1 in order. No write ever happens outside ESCREVE.
- Reset in mid-fill aborts the fill immediately. Already-written entries stay in memory, no further write occurs, and `pronto` is not pulsed.
- `iniciar` held high across FIM restarts the fill with no idle cycle.

## Structure
- Shared package holds:
  - state codes;
  - the one-hot mapping function;
  - LFSR width and tap constants.
- One sub-module, `lfsr16`, with ports clock, reset, parameter SEED and output `q[15:0]`.
- The FSM, counter, data register and arbitration mux stay in `gerador_sequencia`.

## Test plan
- Reset while `iniciar`=0 → all outputs at their reset values; `mem_endereco` tracks `endereco_jogo` stepped 0..15 in the same cycle.
- SEM_REPETICAO=0, single `iniciar` pulse → 16 `mem_we` pulses at addresses 0..15, each `mem_dado` one-hot and matching the reference-model LFSR; `pronto` pulses at k+50.
- SEM_REPETICAO=1, 20 fills → no two consecutive written entries equal; cycle count = 50 plus the number of rejections seen.
- `iniciar` pulsed at cycles k+10 and k+30 during a fill → no restart, address sequence unchanged, exactly one `pronto`.
- `reset` asserted at k+20 → `mem_we` and `ocupado` low immediately, `db_estado`=0, no `pronto`; a new `iniciar` then produces a complete fill from address 0.
- `iniciar` held high continuously → back-to-back fills, FIM followed directly by ZERA, `pronto` every 50 cycles when no rejections occur.
